// File: rtl/iir_power_meter.sv
// -----------------------------------------------------------------------------
// iir_power_meter
// Block-averaged power meter for the complex output stream of iir_filter.
// Each valid sample contributes p = re^2 + im^2 (exact, unsigned 2*DW bits).
// Every N = 2^LOG2N valid samples the truncated block mean is presented on an
// AXI-Stream style output register together with an 8-bit block sequence
// number. A result arriving while the previous one is still unaccepted is
// dropped and the sticky overflow flag is raised.
//
// Optional feature: define IIR_POWER_METER_PEAK_EN to track the largest p of
// each block and present it on peak_out alongside the mean. Without the macro
// peak_out is constant zero.
//
// Parameters:
//   DW     signed sample width
//   LOG2N  block length exponent, N = 2^LOG2N (1..10)
// Ports:
//   clk            sole clock, rising edge
//   resetn         synchronous active-low reset
//   clear          synchronous block restart (discards in-flight samples)
//   dv_in          sample valid
//   d_in_real      signed in-phase sample
//   d_in_imag      signed quadrature sample
//   m_axis_tvalid  result valid
//   m_axis_tready  downstream accept
//   m_axis_tdata   {seq[7:0], zero pad, mean_power}
//   peak_out       peak p of the block, qualified by m_axis_tvalid
//   overflow       sticky: a completed block result was dropped
// -----------------------------------------------------------------------------
module iir_power_meter #(
    parameter int DW    = 18,
    parameter int LOG2N = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 dv_in,
    input  logic signed [DW-1:0] d_in_real,
    input  logic signed [DW-1:0] d_in_imag,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [47:0]          m_axis_tdata,
    output logic [2*DW-1:0]      peak_out,
    output logic                 overflow
);
    localparam int PW = 2 * DW;
    localparam int AW = PW + LOG2N;

    typedef enum logic {EMPTY, FULL} state_t;

    logic signed [DW-1:0] sample [2];
    assign sample[0] = d_in_real;
    assign sample[1] = d_in_imag;

    // Stage 1: one squarer per component
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sq
            logic signed [PW-1:0] prod;
            logic [PW-1:0]        sq_reg;
            // Operands are sign-extended first so the product is the exact square
            assign prod = PW'(sample[gi]) * PW'(sample[gi]);
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    sq_reg <= '0;
                end else if (dv_in && !clear) begin
                    sq_reg <= prod;
                end
            end
        end
    endgenerate

    logic           s1_valid_reg, s2_valid_reg;
    logic [PW-1:0]  p_reg;
    logic [AW-1:0]  acc_reg;
    logic [LOG2N-1:0] count_reg;
    logic [7:0]     seq_reg;
    logic [PW-1:0]  mean_reg;
    logic [7:0]     tseq_reg;
    logic           overflow_reg;
    state_t         state_reg, state_next;

    logic [AW-1:0]  acc_sum;
    logic [PW-1:0]  mean_next;
    logic           block_done;
    logic           fire;
    logic           take_result;
    logic           drop_result;

    // Valid bits travel every cycle; stages only act on valid data, so dv_in
    // gaps never disturb the accumulation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            p_reg        <= '0;
        end else begin
            s1_valid_reg <= dv_in && !clear;
            s2_valid_reg <= s1_valid_reg && !clear;
            if (s1_valid_reg && !clear) begin
                p_reg <= g_sq[0].sq_reg + g_sq[1].sq_reg;
            end
        end
    end

    // Stage 3: accumulate; the last sample of a block closes it
    assign acc_sum    = acc_reg + AW'(p_reg);
    assign mean_next  = PW'(acc_sum >> LOG2N);
    assign block_done = s2_valid_reg && !clear && (count_reg == '1);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (s2_valid_reg) begin
            if (block_done) begin
                acc_reg   <= '0;
                count_reg <= '0;
            end else begin
                acc_reg   <= acc_sum;
                count_reg <= count_reg + LOG2N'(1);
            end
        end
    end

    // Output FSM: a new result may replace the held one only in the cycle the
    // held one is being accepted.
    assign fire = (state_reg == FULL) && m_axis_tready;

    always_comb begin
        state_next  = state_reg;
        take_result = 1'b0;
        drop_result = 1'b0;
        if (fire) begin
            state_next = EMPTY;
        end
        if (block_done) begin
            if (state_reg == EMPTY || fire) begin
                take_result = 1'b1;
                state_next  = FULL;
            end else begin
                drop_result = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= EMPTY;
            mean_reg     <= '0;
            tseq_reg     <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take_result) begin
                mean_reg <= mean_next;
                tseq_reg <= seq_reg;
            end
            // Dropped blocks still consume a sequence number
            if (block_done) begin
                seq_reg <= seq_reg + 8'd1;
            end
            if (clear) begin
                overflow_reg <= 1'b0;
            end else if (drop_result) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef IIR_POWER_METER_PEAK_EN
    logic [PW-1:0] peak_acc_reg;
    logic [PW-1:0] peak_reg;
    logic [PW-1:0] peak_new;

    assign peak_new = (p_reg > peak_acc_reg) ? p_reg : peak_acc_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            peak_acc_reg <= '0;
            peak_reg     <= '0;
        end else begin
            if (clear || block_done) begin
                peak_acc_reg <= '0;
            end else if (s2_valid_reg) begin
                peak_acc_reg <= peak_new;
            end
            if (take_result) begin
                peak_reg <= peak_new;
            end
        end
    end

    assign peak_out = peak_reg;
`else
    assign peak_out = '0;
`endif

    assign m_axis_tvalid = (state_reg == FULL);
    assign m_axis_tdata  = {tseq_reg, 40'(mean_reg)};
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_iir_power_meter.sv
// -----------------------------------------------------------------------------
// tb_iir_power_meter
// Directed bench for iir_power_meter (DW=18, LOG2N=2). Stimulus pushes the
// expected block result into a queue; an independent monitor pops and checks
// every accepted output beat. Expected peak follows IIR_POWER_METER_PEAK_EN.
// -----------------------------------------------------------------------------
module tb_iir_power_meter;
    localparam int DW    = 18;
    localparam int LOG2N = 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 clear;
    logic                 dv_in;
    logic signed [DW-1:0] d_in_real;
    logic signed [DW-1:0] d_in_imag;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [47:0]          m_axis_tdata;
    logic [2*DW-1:0]      peak_out;
    logic                 overflow;

    iir_power_meter #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (clear),
        .dv_in         (dv_in),
        .d_in_real     (d_in_real),
        .d_in_imag     (d_in_imag),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .peak_out      (peak_out),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] mean;
        logic [7:0]  seq;
        logic [35:0] peak;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [35:0] exp_peak(input logic [35:0] p);
`ifdef IIR_POWER_METER_PEAK_EN
        return p;
`else
        return 36'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: every accepted beat is compared against the scoreboard head
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got tdata=%0h with no result pending", m_axis_tdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mean", 64'(m_axis_tdata[35:0]), 64'(e.mean));
                chk("seq",  64'(m_axis_tdata[47:40]), 64'(e.seq));
                chk("pad",  64'(m_axis_tdata[39:36]), 64'd0);
                chk("peak", 64'(peak_out), 64'(e.peak));
                $display("beat: seq=%0d mean=%0d peak=%0d", m_axis_tdata[47:40], m_axis_tdata[35:0], peak_out);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im, input int gap, input logic clr);
        d_in_real = DW'(re);
        d_in_imag = DW'(im);
        dv_in     = 1'b1;
        clear     = clr;
        step();
        dv_in = 1'b0;
        clear = 1'b0;
        repeat (gap) step();
    endtask

    task automatic push(input logic [35:0] mean, input logic [7:0] seq, input logic [35:0] pk);
        exp_t e;
        e.mean = mean;
        e.seq  = seq;
        e.peak = exp_peak(pk);
        sb.push_back(e);
    endtask

    // Four identical samples; mean and peak both equal p
    task automatic block(input int re, input int im);
        for (int i = 0; i < 4; i++) send(re, im, 0, 1'b0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && k < 60) begin
            step();
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        resetn        = 1'b0;
        clear         = 1'b0;
        dv_in         = 1'b0;
        d_in_real     = '0;
        d_in_imag     = '0;
        m_axis_tready = 1'b1;
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_peak", 64'(peak_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;
        step();

        // 1: p=10000 back-to-back, latency of 3 cycles after the 4th sample
        push(36'd10000, 8'd0, 36'd10000);
        for (int i = 0; i < 3; i++) send(100, 0, 0, 1'b0);
        send(100, 0, 0, 1'b0);
        chk("lat_t1", 64'(m_axis_tvalid), 64'd0);
        step();
        chk("lat_t2", 64'(m_axis_tvalid), 64'd0);
        step();
        chk("lat_t3", 64'(m_axis_tvalid), 64'd1);
        drain("t1");

        // 2: full-scale negative samples, p = 2^35, no truncation loss
        push(36'd34359738368, 8'd1, 36'd34359738368);
        block(-131072, -131072);
        drain("t2");

        // 3: p = 1,1,4,5 with gaps 0..3 -> 11>>2 = 2, peak 5
        push(36'd2, 8'd2, 36'd5);
        send(1, 0, 0, 1'b0);
        send(0, -1, 1, 1'b0);
        send(0, 2, 2, 1'b0);
        send(-2, 1, 3, 1'b0);
        drain("t3");

        // 4: new result coincides with acceptance of the held one
        m_axis_tready = 1'b0;
        push(36'd25, 8'd3, 36'd25);
        push(36'd100, 8'd4, 36'd100);
        block(3, 4);
        repeat (4) step();
        chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        block(6, 8);
        step();
        m_axis_tready = 1'b1;
        step();
        chk("coincide_overflow", 64'(overflow), 64'd0);
        drain("t4");

        // 5: backpressure across two blocks; second dropped
        m_axis_tready = 1'b0;
        push(36'd169, 8'd5, 36'd169);
        block(5, 12);
        repeat (4) step();
        block(8, 15);
        repeat (4) step();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("held_mean", 64'(m_axis_tdata[35:0]), 64'd169);
        chk("held_seq", 64'(m_axis_tdata[47:40]), 64'd5);
        chk("held_peak", 64'(peak_out), 64'(exp_peak(36'd169)));
        m_axis_tready = 1'b1;
        drain("t5a");
        push(36'd1, 8'd7, 36'd1);
        block(1, 0);
        drain("t5b");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // 6: clear with the 3rd sample; only the following 4 samples count
        push(36'd4, 8'd8, 36'd4);
        send(7, 0, 0, 1'b0);
        send(7, 0, 0, 1'b0);
        send(7, 0, 0, 1'b1);
        chk("clr_overflow", 64'(overflow), 64'd0);
        block(2, 0);
        drain("t6");

        // 7: reset mid-block discards the partial block
        send(20, 0, 0, 1'b0);
        send(20, 0, 0, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("rst2_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst2_overflow", 64'(overflow), 64'd0);
        push(36'd100, 8'd0, 36'd100);
        block(10, 0);
        drain("t7");
        chk("final_overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
